// File: rtl/multdiv_iter_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_iter_pkg
//   Shared definitions for the iterative multiply/divide unit: FSM state
//   encodings, default latencies, the Booth select bundle and the ALU-op codes
//   that decode uses to raise ctrl_mult / ctrl_div.
// -----------------------------------------------------------------------------
package multdiv_iter_pkg;

  // FSM states; 2-bit binary encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // Default datapath width and the latencies it implies.
  localparam int unsigned MD_WIDTH    = 32;
  localparam int unsigned MD_MULT_LAT = MD_WIDTH / 2 + 1;
  localparam int unsigned MD_DIV_LAT  = MD_WIDTH + 1;

  // ALU-op codes shared with decode; decode raises ctrl_mult / ctrl_div
  // when it sees these.
  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  // Radix-4 Booth digit select: digit = (neg ? -1 : +1) * (two ? 2 : 1),
  // or 0 when zero is set.
  typedef struct packed {
    logic neg;
    logic zero;
    logic two;
  } booth_sel_t;

endpackage : multdiv_iter_pkg

// File: rtl/multdiv_iter_booth_recode.sv
// -----------------------------------------------------------------------------
// multdiv_iter_booth_recode
//   Radix-4 Booth recoder: maps the 3-bit multiplier window
//   {b[2i+1], b[2i], b[2i-1]} onto a {neg, zero, two} digit select.
// Ports:
//   window  in  3  multiplier bit window
//   sel     out 3  booth_sel_t {neg, zero, two}
// -----------------------------------------------------------------------------
module multdiv_iter_booth_recode
  import multdiv_iter_pkg::*;
(
  input  logic [2:0] window,
  output booth_sel_t sel
);

  // Window-to-digit table: 000/111 -> 0, 001/010 -> +1, 011 -> +2,
  // 100 -> -2, 101/110 -> -1.
  always_comb begin
    sel = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
    case (window)
      3'b000:  sel = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
      3'b001:  sel = '{neg: 1'b0, zero: 1'b0, two: 1'b0};
      3'b010:  sel = '{neg: 1'b0, zero: 1'b0, two: 1'b0};
      3'b011:  sel = '{neg: 1'b0, zero: 1'b0, two: 1'b1};
      3'b100:  sel = '{neg: 1'b1, zero: 1'b0, two: 1'b1};
      3'b101:  sel = '{neg: 1'b1, zero: 1'b0, two: 1'b0};
      3'b110:  sel = '{neg: 1'b1, zero: 1'b0, two: 1'b0};
      3'b111:  sel = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
      default: sel = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
    endcase
  end

endmodule : multdiv_iter_booth_recode

// File: rtl/multdiv_iter.sv
// -----------------------------------------------------------------------------
// multdiv_iter
//   Iterative signed multiply / divide unit for the execute stage.
//   Multiply: radix-4 Booth, WIDTH/2 iterations (latency MULT_LAT).
//   Divide:   non-restoring on magnitudes, WIDTH iterations with sign fix-up
//             folded into the last one (latency DIV_LAT). Divide faults still
//             run the full latency so stall timing is fixed per operation.
// Ports:
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous active-high reset
//   ctrl_mult   in   1      start signed multiply (wins over ctrl_div)
//   ctrl_div    in   1      start signed divide
//   operand_a   in   WIDTH  multiplicand / dividend
//   operand_b   in   WIDTH  multiplier / divisor
//   result      out  WIDTH  low product bits or quotient
//   exception   out  1      overflow / divide fault, valid with data_ready
//   data_ready  out  1      one-cycle result-valid pulse (state DONE)
//   busy        out  1      operation in flight (pipeline stall request)
// -----------------------------------------------------------------------------
module multdiv_iter
  import multdiv_iter_pkg::*;
#(
  parameter int unsigned WIDTH    = MD_WIDTH,
  parameter int unsigned MULT_LAT = WIDTH / 2 + 1,
  parameter int unsigned DIV_LAT  = WIDTH + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             data_ready,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT);
  localparam int unsigned PW    = 2 * WIDTH + 2;

  // Registered state
  md_state_e          state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   opa_r;          // multiplicand, or divisor magnitude
  logic [PW-1:0]      prod_r;         // {hi[WIDTH+1:0], multiplier/low bits}
  logic               booth_prev_r;   // b[2i-1] of the current window
  logic [WIDTH:0]     rem_r;          // signed partial remainder
  logic [WIDTH-1:0]   quot_r;         // dividend bits out, quotient bits in
  logic               neg_r;
  logic               div_zero_r;
  logic               div_ovf_r;
  logic [WIDTH-1:0]   result_r;
  logic               exception_r;
  logic               data_ready_r;
  logic               busy_r;

  // Combinational
  md_state_e          state_nx_s;
  logic               start_mult_s;
  logic               start_div_s;
  logic               mult_last_s;
  logic               div_last_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  booth_sel_t         booth_sel_s;
  logic [WIDTH+1:0]   mcand_ext_s;
  logic [WIDTH+1:0]   pp_mag_s;
  logic [WIDTH+1:0]   pp_s;
  logic [WIDTH+1:0]   hi_sum_s;
  logic [PW-1:0]      prod_nx_s;
  logic               mult_ovf_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH:0]     divisor_ext_s;
  logic [WIDTH:0]     rem_nx_s;
  logic [WIDTH-1:0]   quot_nx_s;
  logic [WIDTH-1:0]   div_res_s;

  assign result     = result_r;
  assign exception  = exception_r;
  assign data_ready = data_ready_r;
  assign busy       = busy_r;

  assign mult_last_s = (cnt_r == CNT_W'(MULT_LAT - 2));
  assign div_last_s  = (cnt_r == CNT_W'(DIV_LAT - 2));

  // Booth digit for the current multiplier window.
  multdiv_iter_booth_recode u_booth_recode (
    .window ({prod_r[1:0], booth_prev_r}),
    .sel    (booth_sel_s)
  );

  // Operand magnitudes for the divider, taken on the accepting edge.
  always_comb begin
    a_mag_s = operand_a;
    b_mag_s = operand_b;
    if (operand_a[WIDTH-1]) begin
      a_mag_s = (~operand_a) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      a_mag_s = operand_a;
    end
    if (operand_b[WIDTH-1]) begin
      b_mag_s = (~operand_b) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      b_mag_s = operand_b;
    end
  end

  // One Booth step: add the sign-extended partial product into the high
  // half, then shift the whole product register right arithmetically by 2.
  always_comb begin
    mcand_ext_s = {{2{opa_r[WIDTH-1]}}, opa_r};
    pp_mag_s    = {(WIDTH+2){1'b0}};
    pp_s        = {(WIDTH+2){1'b0}};
    if (booth_sel_s.zero) begin
      pp_mag_s = {(WIDTH+2){1'b0}};
    end else if (booth_sel_s.two) begin
      pp_mag_s = {mcand_ext_s[WIDTH:0], 1'b0};
    end else begin
      pp_mag_s = mcand_ext_s;
    end
    if (booth_sel_s.neg) begin
      pp_s = (~pp_mag_s) + {{(WIDTH+1){1'b0}}, 1'b1};
    end else begin
      pp_s = pp_mag_s;
    end
    hi_sum_s  = prod_r[PW-1:WIDTH] + pp_s;
    prod_nx_s = {{2{hi_sum_s[WIDTH+1]}}, hi_sum_s, prod_r[WIDTH-1:2]};
    // Signed overflow: bits [2W-1:W-1] of the product are not a pure sign run.
    mult_ovf_s = !((&prod_nx_s[2*WIDTH-1:WIDTH-1]) || (~|prod_nx_s[2*WIDTH-1:WIDTH-1]));
  end

  // One non-restoring step. The shift is modulo 2^(WIDTH+1); the true
  // partial remainder always fits, so the dropped top bit is harmless.
  // The quotient bits match restoring division, so no quotient correction.
  always_comb begin
    rem_shift_s   = {rem_r[WIDTH-1:0], quot_r[WIDTH-1]};
    divisor_ext_s = {1'b0, opa_r};
    if (rem_r[WIDTH]) begin
      rem_nx_s = rem_shift_s + divisor_ext_s;
    end else begin
      rem_nx_s = rem_shift_s - divisor_ext_s;
    end
    quot_nx_s = {quot_r[WIDTH-2:0], ~rem_nx_s[WIDTH]};
    if (div_zero_r) begin
      div_res_s = {WIDTH{1'b0}};
    end else if (div_ovf_r) begin
      div_res_s = {1'b1, {(WIDTH-1){1'b0}}};
    end else if (neg_r) begin
      div_res_s = (~quot_nx_s) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      div_res_s = quot_nx_s;
    end
  end

  // Next-state and start decode; ctrl_* are only looked at in IDLE/DONE.
  always_comb begin
    state_nx_s   = state_r;
    start_mult_s = 1'b0;
    start_div_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (ctrl_mult) begin
          start_mult_s = 1'b1;
          state_nx_s   = ST_MULT;
        end else if (ctrl_div) begin
          start_div_s = 1'b1;
          state_nx_s  = ST_DIV;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (mult_last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_MULT;
        end
      end
      ST_DIV: begin
        if (div_last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DIV;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      opa_r        <= {WIDTH{1'b0}};
      prod_r       <= {PW{1'b0}};
      booth_prev_r <= 1'b0;
      rem_r        <= {(WIDTH+1){1'b0}};
      quot_r       <= {WIDTH{1'b0}};
      neg_r        <= 1'b0;
      div_zero_r   <= 1'b0;
      div_ovf_r    <= 1'b0;
      result_r     <= {WIDTH{1'b0}};
      exception_r  <= 1'b0;
      data_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      busy_r       <= (state_nx_s == ST_MULT) || (state_nx_s == ST_DIV);
      data_ready_r <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_mult_s) begin
            cnt_r        <= {CNT_W{1'b0}};
            opa_r        <= operand_a;
            prod_r       <= {{(WIDTH+2){1'b0}}, operand_b};
            booth_prev_r <= 1'b0;
            exception_r  <= 1'b0;
          end else if (start_div_s) begin
            cnt_r       <= {CNT_W{1'b0}};
            opa_r       <= b_mag_s;
            rem_r       <= {(WIDTH+1){1'b0}};
            quot_r      <= a_mag_s;
            neg_r       <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div_zero_r  <= ~|operand_b;
            div_ovf_r   <= (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b);
            exception_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_MULT: begin
          prod_r       <= prod_nx_s;
          booth_prev_r <= prod_r[1];
          cnt_r        <= cnt_r + CNT_W'(1);
          if (mult_last_s) begin
            result_r    <= prod_nx_s[WIDTH-1:0];
            exception_r <= mult_ovf_s;
          end else begin
            result_r <= result_r;
          end
        end
        ST_DIV: begin
          rem_r  <= rem_nx_s;
          quot_r <= quot_nx_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (div_last_s) begin
            result_r    <= div_res_s;
            exception_r <= div_zero_r | div_ovf_r;
          end else begin
            result_r <= result_r;
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule : multdiv_iter

// File: tb/tb_multdiv_iter.sv
// -----------------------------------------------------------------------------
// tb_multdiv_iter
//   Directed self-checking bench for multdiv_iter with hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_multdiv_iter;

  localparam int MLAT = 17;
  localparam int DLAT = 33;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div  = 1'b0;
  logic [31:0] operand_a = 32'h0000_0000;
  logic [31:0] operand_b = 32'h0000_0000;
  logic [31:0] result;
  logic        exception;
  logic        data_ready;
  logic        busy;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  multdiv_iter dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .exception  (exception),
    .data_ready (data_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a start request for one edge; returns #1 after that edge (edge 0).
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = m;
    ctrl_div  = d;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = 32'h5A5A_5A5A;
    operand_b = 32'hA5A5_A5A5;
  endtask

  // Wait for data_ready (bounded) and check latency, busy span and outputs.
  // poke_at > 0 raises both ctrl lines in that sample cycle while busy.
  task automatic await_result(input string tag, input int lat, input int poke_at,
                              input logic [31:0] exp_res, input logic exp_exc);
    int n;
    int busy_n;
    n      = 1;
    busy_n = 0;
    while (data_ready !== 1'b1 && n <= 100) begin
      if (busy === 1'b1) busy_n++;
      if (n == poke_at) begin
        ctrl_mult = 1'b1;
        ctrl_div  = 1'b1;
        operand_a = 32'h0000_0003;
        operand_b = 32'h0000_0005;
      end else begin
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
      end
      @(posedge clock);
      #1;
      n++;
    end
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    check_value({tag, " latency"}, n, lat);
    check_value({tag, " busy_cycles"}, busy_n, lat - 1);
    check_value({tag, " result"}, result, exp_res);
    check_value({tag, " exception"}, {31'd0, exception}, {31'd0, exp_exc});
    check_value({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  // One cycle after DONE with no request: pulse gone, outputs held.
  task automatic idle_tick(input string tag, input logic [31:0] exp_res, input logic exp_exc);
    @(posedge clock);
    #1;
    check_value({tag, " ready_pulse_end"}, {31'd0, data_ready}, 32'd0);
    check_value({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    check_value({tag, " result_hold"}, result, exp_res);
    check_value({tag, " exception_hold"}, {31'd0, exception}, {31'd0, exp_exc});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    check_value("rst result", result, 32'h0000_0000);
    check_value("rst exception", {31'd0, exception}, 32'd0);
    check_value("rst data_ready", {31'd0, data_ready}, 32'd0);
    check_value("rst busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Multiply vectors
    start_op(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    await_result("mul 7*-3", MLAT, 0, 32'hFFFF_FFEB, 1'b0);
    idle_tick("mul 7*-3", 32'hFFFF_FFEB, 1'b0);

    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    await_result("mul 2^16*2^16", MLAT, 0, 32'h0000_0000, 1'b1);
    idle_tick("mul 2^16*2^16", 32'h0000_0000, 1'b1);

    start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0002);
    await_result("mul max*2", MLAT, 0, 32'hFFFF_FFFE, 1'b1);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    await_result("mul min*-1", MLAT, 0, 32'h8000_0000, 1'b1);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
    await_result("mul min*1", MLAT, 0, 32'h8000_0000, 1'b0);
    idle_tick("mul min*1", 32'h8000_0000, 1'b0);

    // Divide vectors
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    await_result("div -7/2", DLAT, 0, 32'hFFFF_FFFD, 1'b0);
    idle_tick("div -7/2", 32'hFFFF_FFFD, 1'b0);
    start_op(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000);
    await_result("div 5/0", DLAT, 0, 32'h0000_0000, 1'b1);
    idle_tick("div 5/0", 32'h0000_0000, 1'b1);
    start_op(1'b0, 1'b1, 32'h0000_0064, 32'hFFFF_FFF9);
    await_result("div 100/-7", DLAT, 0, 32'hFFFF_FFF2, 1'b0);
    start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    await_result("div -100/-7", DLAT, 0, 32'h0000_000E, 1'b0);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001);
    await_result("div min/1", DLAT, 0, 32'h8000_0000, 1'b0);
    idle_tick("div min/1", 32'h8000_0000, 1'b0);

    // Requests while busy are ignored; both ctrl lines at once -> multiply
    start_op(1'b1, 1'b0, 32'h0000_007B, 32'hFFFF_FFD3);
    await_result("mul poke", MLAT, 4, 32'hFFFF_EA61, 1'b0);
    idle_tick("mul poke", 32'hFFFF_EA61, 1'b0);
    start_op(1'b1, 1'b1, 32'h0000_0009, 32'h0000_000B);
    await_result("mul+div both", MLAT, 0, 32'h0000_0063, 1'b0);
    idle_tick("mul+div both", 32'h0000_0063, 1'b0);

    // Back-to-back starts issued in the DONE cycle
    start_op(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
    await_result("b2b 3*4", MLAT, 0, 32'h0000_000C, 1'b0);
    start_op(1'b1, 1'b0, 32'h0000_0006, 32'h0000_0007);
    await_result("b2b 6*7", MLAT, 0, 32'h0000_002A, 1'b0);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    await_result("b2b min/-1", DLAT, 0, 32'h8000_0000, 1'b1);

    // Asynchronous reset in cycle 5 of a divide
    start_op(1'b0, 1'b1, 32'h0000_0064, 32'h0000_0007);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    check_value("midrst result", result, 32'h0000_0000);
    check_value("midrst exception", {31'd0, exception}, 32'd0);
    check_value("midrst data_ready", {31'd0, data_ready}, 32'd0);
    check_value("midrst busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check_value("post-rst busy", {31'd0, busy}, 32'd0);

    // Recovery after reset
    start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    await_result("mul -5*-6", MLAT, 0, 32'h0000_001E, 1'b0);
    idle_tick("mul -5*-6", 32'h0000_001E, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_multdiv_iter
